// File: rtl/i2c_slave_resp.sv
// i2c_slave_resp: I2C target with a 7-bit address.
// Acknowledges its own address, hands each received write byte to the fabric,
// and shifts out fabric-supplied bytes on reads. Bus pins are only sampled
// through synchronisers; SDA is driven open-drain via sda_oe.
`timescale 1ns/1ps
module i2c_slave_resp #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] tx_dat,
   output logic       tx_req,
   output logic [7:0] rx_dat,
   output logic       rx_valid,
   output logic       busy,
   output logic       rw
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
   } state_t;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic       rx_pend;

   // _p0/_p1 form the synchroniser, _p2 is the delayed copy for edge detection
   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   logic scl_rise, scl_fall, start_det, stop_det;

   // Two-flop synchronisers plus one history flop per bus line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl_in;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda_in;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign scl_rise  =  scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 &  scl_p2;
   assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
   assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;

   // Protocol FSM; bus conditions override any SCL edge seen in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= 8'h00;
         rx_pend  <= 1'b0;
         sda_oe   <= 1'b0;
         tx_req   <= 1'b0;
         rx_valid <= 1'b0;
         rx_dat   <= 8'h00;
         busy     <= 1'b0;
         rw       <= 1'b0;
      end else begin
         tx_req   <= 1'b0;
         rx_valid <= 1'b0;

         // A completed write byte is published one cycle after its last bit
         if (rx_pend) begin
            rx_dat   <= shreg;
            rx_valid <= 1'b1;
            rx_pend  <= 1'b0;
         end

         if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else begin
            case (state)
               IDLE: ;

               ADDR: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     shreg   <= {shreg[6:0], sda_p1};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        // shreg[6:0] already holds the seven address bits
                        if (shreg[6:0] == SLAVE_ADDR) begin
                           rw   <= sda_p1;
                           busy <= 1'b1;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sda_oe <= 1'b1;
                     state  <= ADDR_ACK;
                  end
               end

               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!rw) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= RX_BYTE;
                     end else begin
                        tx_req  <= 1'b1;
                        shreg   <= tx_dat;
                        sda_oe  <= ~tx_dat[7];
                        bit_cnt <= 4'd1;
                        state   <= TX_BYTE;
                     end
                  end
               end

               RX_BYTE: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     shreg   <= {shreg[6:0], sda_p1};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) rx_pend <= 1'b1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sda_oe <= 1'b1;
                     state  <= RX_ACK;
                  end
               end

               RX_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= RX_BYTE;
                  end
               end

               // bit_cnt counts bits already presented; shreg[7] is on the bus
               TX_BYTE: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        state  <= TX_ACK;
                     end else begin
                        sda_oe  <= ~shreg[6];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end

               // A NACK ends the transfer at once; an ACK reloads on the next fall
               TX_ACK: begin
                  if (scl_rise && sda_p1) begin
                     state <= WAIT_STOP;
                     busy  <= 1'b0;
                  end else if (scl_fall) begin
                     tx_req  <= 1'b1;
                     shreg   <= tx_dat;
                     sda_oe  <= ~tx_dat[7];
                     bit_cnt <= 4'd1;
                     state   <= TX_BYTE;
                  end
               end

               WAIT_STOP: ;

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_resp.sv
// tb_i2c_slave_resp: directed bus-master sequences against i2c_slave_resp.
`timescale 1ns/1ps
module tb_i2c_slave_resp;

   localparam int Q = 60;   // quarter SCL period in ns (SCL = 24 clk)

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] tx_dat = 8'h00;
   logic       sda_oe, tx_req, rx_valid, busy, rw;
   logic [7:0] rx_dat;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_resp #(.SLAVE_ADDR(7'h50)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_m),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .tx_dat   (tx_dat),
      .tx_req   (tx_req),
      .rx_dat   (rx_dat),
      .rx_valid (rx_valid),
      .busy     (busy),
      .rw       (rw)
   );

   int         n_assert = 0;
   int         n_fail = 0;
   int         rx_cnt = 0;
   int         tx_cnt = 0;
   int         oe_cnt = 0;
   logic [7:0] rx_log [0:15];

   // Pulse counters and received-byte log
   always @(negedge clk) begin
      if (rx_valid) begin
         if (rx_cnt < 16) rx_log[rx_cnt] <= rx_dat;
         rx_cnt <= rx_cnt + 1;
      end
      if (tx_req) tx_cnt <= tx_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_clk(input logic b, output logic s);
      sda_m = b;
      #Q; scl_m = 1'b1;
      #Q; s = sda_line;
      #Q; scl_m = 1'b0;
      #Q;
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      #Q; scl_m = 1'b1;
      #Q; sda_m = 1'b0;
      #Q; scl_m = 1'b0;
      #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      #Q; scl_m = 1'b1;
      #Q; sda_m = 1'b1;
      #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack_n);
      logic s;
      for (int i = 7; i >= 0; i--) bit_clk(d[i], s);
      bit_clk(1'b1, ack_n);
   endtask

   // ack=1: master acknowledges; nxt is offered on tx_dat before the ACK clock
   task automatic read_byte(input logic ack, input logic [7:0] nxt, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) bit_clk(1'b1, d[i]);
      tx_dat = nxt;
      bit_clk(~ack, s);
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      int         r0, t0, o0;

      // Reset values while rst is held low
      #23;
      check("reset_outputs", 32'({sda_oe, tx_req, rx_valid, busy, rw, rx_dat}), 0);
      rst = 1'b1;
      #40;

      // Write 0xA5 to 0x50
      bus_start();
      write_byte(8'hA0, a);
      check("t1_addr_ack", 32'(a), 0);
      check("t1_busy", 32'(busy), 1);
      check("t1_rw", 32'(rw), 0);
      write_byte(8'hA5, a);
      check("t1_data_ack", 32'(a), 0);
      check("t1_rx_dat", 32'(rx_dat), 32'h A5);
      check("t1_rx_valid_cnt", rx_cnt, 1);
      bus_stop();
      #100;
      check("t1_busy_after_stop", 32'(busy), 0);
      check("t1_oe_after_stop", 32'(sda_oe), 0);

      // Address 0x51: ignored entirely
      r0 = rx_cnt; o0 = oe_cnt;
      bus_start();
      write_byte(8'hA2, a);
      check("t2_addr_nack", 32'(a), 1);
      check("t2_busy", 32'(busy), 0);
      write_byte(8'h55, a);
      check("t2_data_nack", 32'(a), 1);
      bus_stop();
      #100;
      check("t2_oe_never", oe_cnt - o0, 0);
      check("t2_no_rx_valid", rx_cnt - r0, 0);

      // Read 0x3C from 0x50, master NACK
      tx_dat = 8'h3C; t0 = tx_cnt;
      bus_start();
      write_byte(8'hA1, a);
      check("t3_addr_ack", 32'(a), 0);
      check("t3_rw", 32'(rw), 1);
      read_byte(1'b0, 8'h00, d);
      check("t3_read_data", 32'(d), 32'h3C);
      check("t3_tx_req_cnt", tx_cnt - t0, 1);
      check("t3_busy_after_nack", 32'(busy), 0);
      check("t3_oe_after_nack", 32'(sda_oe), 0);
      // Clocking after the NACK must be ignored
      read_byte(1'b1, 8'h00, d);
      check("t3_wait_stop_idle_bus", 32'(d), 32'hFF);
      check("t3_tx_req_after_nack", tx_cnt - t0, 1);
      bus_stop();
      #100;
      check("t3_busy_after_stop", 32'(busy), 0);

      // Three-byte write
      r0 = rx_cnt;
      bus_start();
      write_byte(8'hA0, a);
      check("t4_addr_ack", 32'(a), 0);
      write_byte(8'h11, a);
      check("t4_ack0", 32'(a), 0);
      write_byte(8'h22, a);
      check("t4_ack1", 32'(a), 0);
      write_byte(8'h33, a);
      check("t4_ack2", 32'(a), 0);
      bus_stop();
      #100;
      check("t4_rx_valid_cnt", rx_cnt - r0, 3);
      check("t4_byte0", 32'(rx_log[r0]), 32'h11);
      check("t4_byte1", 32'(rx_log[r0+1]), 32'h22);
      check("t4_byte2", 32'(rx_log[r0+2]), 32'h33);

      // Write 0x01, repeated START, read 0xF0 (ACK) then 0x0F (NACK)
      t0 = tx_cnt;
      bus_start();
      write_byte(8'hA0, a);
      check("t5_waddr_ack", 32'(a), 0);
      write_byte(8'h01, a);
      check("t5_wdata_ack", 32'(a), 0);
      check("t5_rw_write", 32'(rw), 0);
      check("t5_rx_dat", 32'(rx_dat), 32'h01);
      tx_dat = 8'hF0;
      bus_start();
      write_byte(8'hA1, a);
      check("t5_raddr_ack", 32'(a), 0);
      check("t5_rw_read", 32'(rw), 1);
      read_byte(1'b1, 8'h0F, d);
      check("t5_read0", 32'(d), 32'hF0);
      read_byte(1'b0, 8'h00, d);
      check("t5_read1", 32'(d), 32'h0F);
      check("t5_tx_req_cnt", tx_cnt - t0, 2);
      bus_stop();
      #100;

      // Reset asserted while the address ACK is being driven
      bus_start();
      for (int i = 7; i >= 0; i--) bit_clk(((8'hA0 >> i) & 8'h01) != 0, a);
      sda_m = 1'b1;
      #Q; scl_m = 1'b1;
      #Q;
      check("t6_oe_during_ack", 32'(sda_oe), 1);
      rst = 1'b0;
      #1;
      check("t6_async_oe", 32'(sda_oe), 0);
      check("t6_reset_outputs", 32'({sda_oe, tx_req, rx_valid, busy, rw, rx_dat}), 0);
      #50;
      rst = 1'b1;
      #Q; scl_m = 1'b0;
      #Q;
      bus_stop();
      #100;
      bus_start();
      write_byte(8'hA0, a);
      check("t6_addr_ack", 32'(a), 0);
      write_byte(8'h5A, a);
      check("t6_data_ack", 32'(a), 0);
      bus_stop();
      #100;
      check("t6_rx_dat", 32'(rx_dat), 32'h5A);
      check("t6_busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_resp.md
Name: i2c_slave_resp

Overview:
- I2C target (responder) block: the far end of the team's I2C master on the same two-wire bus.
- Decodes START/STOP and a 7-bit address, then acknowledges it.
- Write transfers: receives bytes and presents each one to the fabric.
- Read transfers: shifts out bytes supplied by the fabric.
- Instantiated on the bench and in loopback builds opposite the multi-protocol top's I2C master.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target acknowledges.

Ports:
- clk  input  1  system clock; period ≤ 1/20 of SCL period.
- rst  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL line level, unsynchronised.
- sda_in  input  1  SDA line level, unsynchronised.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- tx_dat  input  8  byte to return on a read; sampled when tx_req pulses.
- tx_req  output  1  one-cycle pulse: tx_dat latched for the next read byte.
- rx_dat  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse: rx_dat updated.
- busy  output  1  1 from an address match until STOP/mismatch/NACK end.
- rw  output  1  R/W bit of the current transfer (1 = read).

Behaviour:
- Reset (rst low, asynchronous) forces the following, regardless of bus activity:
  - State IDLE.
  - sda_oe=0, tx_req=0, rx_valid=0, busy=0, rw=0, rx_dat=8'h00.
  - Bit counter=0; synchroniser flops=1.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchroniser, plus one registered copy used for edge detection.
  - Edge/condition detects are single-cycle and derived from the synchronised signals only.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
- Sampling and driving:
  - Data is sampled on SCL rising edges.
  - sda_oe changes only on SCL falling edges, except reset and STOP, which release it immediately.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- IDLE -> ADDR on START; bit counter cleared.
- ADDR: shift 8 bits MSB-first (7 address bits + R/W).
  - On the 8th rising edge, if address == SLAVE_ADDR: latch rw, set busy; on the following SCL fall drive sda_oe=1 and enter ADDR_ACK.
  - On mismatch: go to IDLE, never drive SDA, ignore everything until the next START.
- ADDR_ACK, on the SCL fall ending the ACK clock:
  - rw=0: release SDA and go to RX_BYTE.
  - rw=1: pulse tx_req, latch tx_dat into the shift register, drive its MSB (sda_oe = ~bit) and go to TX_BYTE.
- RX_BYTE: shift 8 bits MSB-first.
  - One cycle after the 8th rising edge is detected: rx_dat ← shift register and rx_valid pulses.
  - Next SCL fall: drive ACK (sda_oe=1) and enter RX_ACK.
- RX_ACK: on SCL fall, release SDA and return to RX_BYTE. Unlimited bytes; the target always ACKs writes.
- TX_BYTE: on each SCL fall present the next bit; after 8 bits, release SDA on the fall and enter TX_ACK.
- TX_ACK: sample SDA on the SCL rising edge.
  - SDA=0 (master ACK): on the next fall pulse tx_req, load tx_dat, present its MSB, go to TX_BYTE.
  - SDA=1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore SCL; only START or STOP leave this state.
- STOP in any state: IDLE, sda_oe=0, busy=0 within 1 clk of detection.
- Repeated START in any state: go to ADDR, release SDA, clear busy, clear the bit counter.
- Simultaneous conditions: START/STOP detection takes priority over any SCL edge processed in the same cycle.
- Latency: pin edge to internal detection = 3 clk; SCL fall at pin to sda_oe change ≤ 4 clk.
- rx_dat holds its value until the next complete byte. A partial byte aborted by START/STOP produces no rx_valid.

Test Plan:
- Write to 0x50 with byte 0xA5 (bus bits 1010000_0, then 10100101), then STOP -> ACK after address and after the data byte (sda_oe=1 during 9th clocks); rx_dat=0xA5; exactly one rx_valid pulse; busy falls after STOP.
- Address 0x51 write -> sda_oe stays 0 for the whole transfer; busy=0; no rx_valid.
- Read from 0x50 with tx_dat=0x3C, master NACK, STOP -> one tx_req pulse; SDA bits 0,0,1,1,1,1,0,0; state WAIT_STOP then IDLE at STOP.
- 3-byte write 0x11, 0x22, 0x33 -> three rx_valid pulses in order with rx_dat 0x11/0x22/0x33; three data ACKs.
- Write of 0x01 then repeated START and read of 2 bytes (tx_dat 0xF0, then 0x0F; ACK then NACK) -> rw goes 0→1; two tx_req pulses; SDA carries 0xF0 then 0x0F.
- Assert rst while sda_oe=1 during an address ACK -> sda_oe=0 asynchronously; all outputs at reset values; after release, a new write to 0x50 completes normally.
